// File: rtl/controller_painter.sv
// controller_painter: registered RGB stage that blanks the colour outside the visible raster
// and drives the video DAC's blank_n/sync_n controls.
module controller_painter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vidOn,
    input  logic [9:0]  hCounter,
    input  logic [9:0]  vCounter,
    input  logic [23:0] color,
    output logic [7:0]  blue,
    output logic [7:0]  green,
    output logic [7:0]  red,
    output logic        blank_n,
    output logic        sync_n
);
    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM = 11'(V_ACTIVE);
    logic vis;
    // counters past the active area stay blanked even if vidOn is mis-timed
    assign vis = vidOn && ({1'b0, hCounter} < H_LIM) && ({1'b0, vCounter} < V_LIM);
    assign sync_n = 1'b0;
    always_ff @(posedge clk) begin
        if (reset) begin
            red     <= 8'h00;
            green   <= 8'h00;
            blue    <= 8'h00;
            blank_n <= 1'b0;
        end else begin
            red     <= vis ? color[23:16] : 8'h00;
            green   <= vis ? color[15:8]  : 8'h00;
            blue    <= vis ? color[7:0]   : 8'h00;
            blank_n <= vis;
        end
    end
endmodule

// File: tb/tb_controller_painter.sv
// tb_controller_painter: directed checks of the painter output stage,
// comparing {red, green, blue, blank_n, sync_n} against hand-computed values.
module tb_controller_painter;
    logic        clk = 1'b0;
    logic        reset;
    logic        vidOn;
    logic [9:0]  hCounter;
    logic [9:0]  vCounter;
    logic [23:0] color;
    logic [7:0]  blue, green, red;
    logic        blank_n, sync_n;
    int          tests = 0;
    int          fails = 0;

    controller_painter dut (
        .clk(clk), .reset(reset), .vidOn(vidOn), .hCounter(hCounter),
        .vCounter(vCounter), .color(color), .blue(blue), .green(green),
        .red(red), .blank_n(blank_n), .sync_n(sync_n)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic v, input int h, input int vc, input logic [23:0] c);
        reset    = r;
        vidOn    = v;
        hCounter = 10'(h);
        vCounter = 10'(vc);
        color    = c;
    endtask

    // {R, G, B, blank_n, sync_n}
    task automatic check(input string tag, input logic [25:0] exp);
        logic [25:0] obs;
        obs = {red, green, blue, blank_n, sync_n};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h_%h_%h bn=%b sn=%b, expected %h_%h_%h bn=%b sn=%b",
                   tag, obs[25:18], obs[17:10], obs[9:2], obs[1], obs[0],
                   exp[25:18], exp[17:10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 1, 0, 0, 24'hFFFFFF);
        tick(); check("reset", {24'h000000, 2'b00});

        drive(0, 1, 15, 20, 24'd49253);
        tick(); check("split", {24'h00C065, 2'b10});

        drive(0, 1, 16, 20, 24'd10293);
        tick(); check("b2b0", {24'h002835, 2'b10});
        drive(0, 1, 17, 20, 24'd95846);
        tick(); check("b2b1", {24'h017666, 2'b10});
        drive(0, 1, 18, 20, 24'd23178);
        tick(); check("b2b2", {24'h005A8A, 2'b10});

        drive(0, 0, 18, 20, 24'h123456);
        tick(); check("blank_vidoff", {24'h000000, 2'b00});
        drive(0, 1, 18, 20, 24'h123456);
        check("latency_hold", {24'h000000, 2'b00});
        tick(); check("blank_vidon", {24'h123456, 2'b10});

        drive(0, 1, 639, 479, 24'hABCDEF);
        tick(); check("edge_last", {24'hABCDEF, 2'b10});
        drive(0, 1, 640, 479, 24'hABCDEF);
        tick(); check("edge_h", {24'h000000, 2'b00});
        drive(0, 1, 639, 480, 24'hABCDEF);
        tick(); check("edge_v", {24'h000000, 2'b00});
        drive(0, 1, 1023, 1023, 24'hABCDEF);
        tick(); check("edge_max", {24'h000000, 2'b00});

        drive(0, 1, 100, 100, 24'h778899);
        tick(); check("pre_rst", {24'h778899, 2'b10});
        drive(1, 1, 101, 100, 24'hFFFFFF);
        tick(); check("mid_rst0", {24'h000000, 2'b00});
        drive(1, 1, 102, 100, 24'h010203);
        tick(); check("mid_rst1", {24'h000000, 2'b00});
        drive(0, 1, 103, 100, 24'h445566);
        check("rst_release", {24'h000000, 2'b00});
        tick(); check("post_rst", {24'h445566, 2'b10});
        drive(0, 1, 104, 100, 24'h000001);
        tick(); check("post_rst2", {24'h000001, 2'b10});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
